// File: rtl/ex_pkg.sv
// Shared execute-stage definitions: datapath widths, multiplier latency and
// the per-stage record carried down the multiplier pipe.
package ex_pkg;

   localparam int XLEN           = 64;
   localparam int PRF_IDX_W      = 6;
   localparam int ROB_IDX_W      = 5;
   localparam int BR_MASK_W      = 5;
   localparam int EX_CYCLES_MULT = 4;

   typedef struct packed {
      logic                 vld;
      logic [XLEN-1:0]      opa;
      logic [XLEN-1:0]      opb;
      logic [XLEN-1:0]      acc;
      logic [PRF_IDX_W-1:0] dest_tag;
      logic [ROB_IDX_W:0]   rob_idx;
      logic [BR_MASK_W-1:0] br_mask;
   } mult_stage_t;

   // True when an op with this mask depends on the resolving branch.
   function automatic logic br_hit(input logic [BR_MASK_W-1:0] br_mask,
                                   input logic [BR_MASK_W-1:0] br_tag_fix);
      return |(br_mask & br_tag_fix);
   endfunction

endpackage

// File: rtl/mult_stage.sv
// One multiplier pipeline register: folds the K-th operand slice into the
// accumulator on advance, and applies branch squash / mask clear even when held.
module mult_stage
   import ex_pkg::*;
#(
   parameter int K = 0,
   parameter int C = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 stall,
   input  logic                 br_recovery,
   input  logic                 br_pred_correct,
   input  logic [BR_MASK_W-1:0] br_tag_fix,
   input  mult_stage_t          prev,
   output mult_stage_t          cur
);

   logic [XLEN-1:0] opa_shifted;
   logic [XLEN-1:0] opb_slice;
   logic [XLEN-1:0] partial;
   logic            do_clear;
   mult_stage_t     nxt;

   assign opa_shifted = prev.opa << (K * C);
   assign opb_slice   = {{(XLEN-C){1'b0}}, prev.opb[K*C +: C]};
   assign partial     = opa_shifted * opb_slice;

   // Recovery and correct-prediction together is illegal; recovery takes priority.
   assign do_clear = br_pred_correct & ~br_recovery;

   always_comb begin
      nxt = cur;
      if (stall) begin
         if (br_recovery && br_hit(cur.br_mask, br_tag_fix)) begin
            nxt.vld = 1'b0;
         end
         if (do_clear) begin
            nxt.br_mask = cur.br_mask & ~br_tag_fix;
         end
      end else begin
         nxt     = prev;
         nxt.acc = prev.acc + partial;
         if (br_recovery && br_hit(prev.br_mask, br_tag_fix)) begin
            nxt.vld = 1'b0;
         end
         if (do_clear) begin
            nxt.br_mask = prev.br_mask & ~br_tag_fix;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur <= '0;
      end else begin
         cur <= nxt;
      end
   end

endmodule

// File: rtl/mult_pipe.sv
// Pipelined XLEN x XLEN -> XLEN (low half) multiplier for the EX stage.
// Issue gating and completion outputs live here; all arithmetic is in mult_stage.
module mult_pipe
   import ex_pkg::*;
#(
   parameter int STAGES = EX_CYCLES_MULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 iss_vld_i,
   input  logic [XLEN-1:0]      iss_opa_i,
   input  logic [XLEN-1:0]      iss_opb_i,
   input  logic [PRF_IDX_W-1:0] iss_dest_tag_i,
   input  logic [ROB_IDX_W:0]   iss_rob_idx_i,
   input  logic [BR_MASK_W-1:0] iss_br_mask_i,
   input  logic                 stall_i,
   input  logic                 br_recovery_i,
   input  logic                 br_pred_correct_i,
   input  logic [BR_MASK_W-1:0] br_tag_fix_i,
   output logic                 done_vld_o,
   output logic [XLEN-1:0]      done_result_o,
   output logic [PRF_IDX_W-1:0] done_dest_tag_o,
   output logic [ROB_IDX_W:0]   done_rob_idx_o,
   output logic [BR_MASK_W-1:0] done_br_mask_o,
   output logic                 busy_o
);

   localparam int C = XLEN / STAGES;

   mult_stage_t iss;
   mult_stage_t stage_in [STAGES];
   mult_stage_t stage_q  [STAGES];

   // Issue is ignored during recovery; stall is handled by stage 0 holding.
   always_comb begin
      iss          = '0;
      iss.vld      = iss_vld_i & ~br_recovery_i;
      iss.opa      = iss_opa_i;
      iss.opb      = iss_opb_i;
      iss.dest_tag = iss_dest_tag_i;
      iss.rob_idx  = iss_rob_idx_i;
      iss.br_mask  = iss_br_mask_i;
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
         assign stage_in[k] = iss;
      end else begin : g_rest
         assign stage_in[k] = stage_q[k-1];
      end

      mult_stage #(
         .K (k),
         .C (C)
      ) u_stage (
         .clk             (clk),
         .rst_n           (rst_n),
         .stall           (stall_i),
         .br_recovery     (br_recovery_i),
         .br_pred_correct (br_pred_correct_i),
         .br_tag_fix      (br_tag_fix_i),
         .prev            (stage_in[k]),
         .cur             (stage_q[k])
      );
   end

   assign done_vld_o      = stage_q[STAGES-1].vld;
   assign done_result_o   = stage_q[STAGES-1].acc;
   assign done_dest_tag_o = stage_q[STAGES-1].dest_tag;
   assign done_rob_idx_o  = stage_q[STAGES-1].rob_idx;
   assign done_br_mask_o  = stage_q[STAGES-1].br_mask;

   always_comb begin
      busy_o = 1'b0;
      for (int i = 0; i < STAGES; i++) begin
         busy_o = busy_o | stage_q[i].vld;
      end
   end

endmodule

// File: tb/tb_mult_pipe.sv
// Directed + random bench for mult_pipe: a scoreboard queue of expected
// completions is filled at issue time and drained by a completion monitor.
module tb_mult_pipe;
   import ex_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 iss_vld_i;
   logic [XLEN-1:0]      iss_opa_i;
   logic [XLEN-1:0]      iss_opb_i;
   logic [PRF_IDX_W-1:0] iss_dest_tag_i;
   logic [ROB_IDX_W:0]   iss_rob_idx_i;
   logic [BR_MASK_W-1:0] iss_br_mask_i;
   logic                 stall_i;
   logic                 br_recovery_i;
   logic                 br_pred_correct_i;
   logic [BR_MASK_W-1:0] br_tag_fix_i;
   logic                 done_vld_o;
   logic [XLEN-1:0]      done_result_o;
   logic [PRF_IDX_W-1:0] done_dest_tag_o;
   logic [ROB_IDX_W:0]   done_rob_idx_o;
   logic [BR_MASK_W-1:0] done_br_mask_o;
   logic                 busy_o;

   typedef struct {
      logic [XLEN-1:0]      res;
      logic [PRF_IDX_W-1:0] tag;
      logic [ROB_IDX_W:0]   rob;
      logic [BR_MASK_W-1:0] mask;
   } exp_t;

   exp_t sb[$];
   int   n_tests  = 0;
   int   n_fail   = 0;
   int   n_pushed = 0;
   int   n_done   = 0;

   mult_pipe dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .iss_vld_i         (iss_vld_i),
      .iss_opa_i         (iss_opa_i),
      .iss_opb_i         (iss_opb_i),
      .iss_dest_tag_i    (iss_dest_tag_i),
      .iss_rob_idx_i     (iss_rob_idx_i),
      .iss_br_mask_i     (iss_br_mask_i),
      .stall_i           (stall_i),
      .br_recovery_i     (br_recovery_i),
      .br_pred_correct_i (br_pred_correct_i),
      .br_tag_fix_i      (br_tag_fix_i),
      .done_vld_o        (done_vld_o),
      .done_result_o     (done_result_o),
      .done_dest_tag_o   (done_dest_tag_o),
      .done_rob_idx_o    (done_rob_idx_o),
      .done_br_mask_o    (done_br_mask_o),
      .busy_o            (busy_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic vld, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [PRF_IDX_W-1:0] tag, input logic [ROB_IDX_W:0] rob,
                        input logic [BR_MASK_W-1:0] mask);
      iss_vld_i      = vld;
      iss_opa_i      = a;
      iss_opb_i      = b;
      iss_dest_tag_i = tag;
      iss_rob_idx_i  = rob;
      iss_br_mask_i  = mask;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, '0, '0, '0);
   endtask

   task automatic push(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [PRF_IDX_W-1:0] tag, input logic [ROB_IDX_W:0] rob,
                       input logic [BR_MASK_W-1:0] mask);
      exp_t e;
      e.res  = a * b;
      e.tag  = tag;
      e.rob  = rob;
      e.mask = mask;
      sb.push_back(e);
      n_pushed++;
   endtask

   // Issue an op that is expected to complete with the given final mask.
   task automatic issue(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [PRF_IDX_W-1:0] tag, input logic [ROB_IDX_W:0] rob,
                        input logic [BR_MASK_W-1:0] mask);
      drive(1'b1, a, b, tag, rob, mask);
      push(a, b, tag, rob, mask);
      tick();
   endtask

   // A completion is consumed on the cycle it is visible and the pipe is not frozen.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done_vld_o === 1'b1 && stall_i === 1'b0) begin
         n_done++;
         check("unexpected_completion", (sb.size() != 0), 1'b1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("result", done_result_o, e.res);
            check("dest_tag", done_dest_tag_o, e.tag);
            check("rob_idx", done_rob_idx_o, e.rob);
            check("br_mask", done_br_mask_o, e.mask);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [XLEN-1:0] a, b, stall_exp;

      rst_n             = 1'b0;
      stall_i           = 1'b0;
      br_recovery_i     = 1'b0;
      br_pred_correct_i = 1'b0;
      br_tag_fix_i      = '0;
      idle();

      #2;
      check("rst_done_vld", done_vld_o, 1'b0);
      check("rst_result", done_result_o, '0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_tag", done_dest_tag_o, '0);
      #10 rst_n = 1'b1;
      tick();

      // basic latency: visible for exactly one cycle, STAGES edges after capture
      issue(64'd3, 64'd5, 6'd7, 6'd9, 5'b0);
      idle();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("lat_done_vld", done_vld_o, (i == 3));
         if (i == 0) check("lat_busy", busy_o, 1'b1);
      end
      tick();

      // wraparound
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd1, 6'd2, 5'b0);
      issue(64'h1_0000_0000, 64'h1_0000_0000, 6'd3, 6'd4, 5'b0);
      idle();
      repeat (6) tick();

      // back-to-back
      for (int i = 0; i < 6; i++) begin
         issue(64'h1234_5678_9ABC_DEF1, 64'(i), 6'(10 + i), 6'(i), 5'b0);
      end
      idle();
      repeat (6) tick();

      // stall with four ops in flight and a fifth waiting at issue
      for (int i = 0; i < 4; i++) begin
         issue(64'hDEAD_BEEF_0000_0001 + 64'(i), 64'h0001_0002_0003_0004 << i, 6'(20 + i), 6'(32 + i), 5'b0);
      end
      stall_exp = 64'hDEAD_BEEF_0000_0001 * 64'h0001_0002_0003_0004;
      stall_i = 1'b1;
      drive(1'b1, 64'd77, 64'd99, 6'd24, 6'd36, 5'b0);
      push(64'd77, 64'd99, 6'd24, 6'd36, 5'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_done_vld", done_vld_o, 1'b1);
         check("stall_result", done_result_o, stall_exp);
         check("stall_busy", busy_o, 1'b1);
         tick();
      end
      stall_i = 1'b0;
      tick();
      idle();
      repeat (7) tick();

      // squash on recovery; issue during recovery ignored
      drive(1'b1, 64'd11, 64'd12, 6'd40, 6'd1, 5'b00010);
      tick();
      issue(64'd13, 64'd14, 6'd41, 6'd2, 5'b00001);
      drive(1'b1, 64'd15, 64'd16, 6'd42, 6'd3, 5'b00011);
      tick();
      br_recovery_i = 1'b1;
      br_tag_fix_i  = 5'b00010;
      drive(1'b1, 64'd17, 64'd18, 6'd43, 6'd4, 5'b0);
      tick();
      br_recovery_i = 1'b0;
      br_tag_fix_i  = '0;
      idle();
      repeat (6) tick();
      check("squash_idle_busy", busy_o, 1'b0);

      // squash of the output stage while stalled
      drive(1'b1, 64'd5, 64'd6, 6'd44, 6'd5, 5'b01000);
      tick();
      idle();
      repeat (3) tick();
      stall_i       = 1'b1;
      br_recovery_i = 1'b1;
      br_tag_fix_i  = 5'b01000;
      @(negedge clk);
      check("out_squash_pre_vld", done_vld_o, 1'b1);
      tick();
      stall_i       = 1'b0;
      br_recovery_i = 1'b0;
      br_tag_fix_i  = '0;
      @(negedge clk);
      check("out_squash_post_vld", done_vld_o, 1'b0);
      check("out_squash_busy", busy_o, 1'b0);
      tick();

      // mask clear: in-flight op and op captured on the clearing edge
      issue(64'd7, 64'd9, 6'd50, 6'd10, 5'b00010);
      br_pred_correct_i = 1'b1;
      br_tag_fix_i      = 5'b00100;
      drive(1'b1, 64'd11, 64'd13, 6'd51, 6'd11, 5'b00101);
      push(64'd11, 64'd13, 6'd51, 6'd11, 5'b00001);
      tick();
      br_pred_correct_i = 1'b0;
      br_tag_fix_i      = '0;
      idle();
      repeat (6) tick();

      // random operands with random gaps
      for (int i = 0; i < 20; i++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         issue(a, b, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)));
         if ($urandom_range(0, 1) == 1) begin
            idle();
            tick();
         end
      end
      idle();
      repeat (6) tick();

      // asynchronous reset mid-flight: in-flight ops are dropped
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 64'd100 + 64'(i), 64'd3, 6'(60 + i), 6'(i), 5'b0);
         tick();
      end
      idle();
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_done_vld", done_vld_o, 1'b0);
      check("mid_rst_result", done_result_o, '0);
      check("mid_rst_tag", done_dest_tag_o, '0);
      check("mid_rst_rob", done_rob_idx_o, '0);
      check("mid_rst_mask", done_br_mask_o, '0);
      check("mid_rst_busy", busy_o, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) tick();
      check("post_rst_busy", busy_o, 1'b0);
      issue(64'd21, 64'd2, 6'd5, 6'd6, 5'b00100);
      idle();
      repeat (6) tick();

      check("sb_empty", sb.size(), 0);
      check("completion_count", n_done, n_pushed);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
